// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Transmit controller for the UART. Accepts a byte through a load/ready
// handshake and serialises an 11-bit-time frame onto tx:
//   eight=1 : start(0), d0..d7, P, stop(1)
//   eight=0 : start(0), d0..d6, P, stop(1), stop(1)
// where P is the even/odd parity of the used data bits when pen=1, else 1.
// Each bit is held for K = max(baud_k, 2) clock cycles.
//
// Handshake: txrdy=1 means a byte may be offered. A byte is accepted on a
// rising edge where load=1 and txrdy=1. A load seen while txrdy=0 is
// ignored completely (no queueing, no side effect).
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   baud_k    in   bit time in clk cycles (0 and 1 behave as 2)
//   eight     in   1 = 8 data bits, 0 = 7 data bits
//   pen       in   parity enable
//   ohel      in   parity sense, 1 = odd, 0 = even
//   load      in   one-cycle write strobe for out_port
//   out_port  in   byte to transmit
//   tx        out  serial output, idles high (registered)
//   txrdy     out  ready to accept a byte (registered)

module uart_tx_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] baud_k,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic        load,
  input  logic [7:0]  out_port,
  output logic        tx,
  output logic        txrdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  data_q;
  logic        eight_q;
  logic        pen_q;
  logic        ohel_q;
  logic [18:0] k_q;
  logic [10:0] sr;
  logic [18:0] tick_cnt;
  logic [3:0]  bit_cnt;

  logic [18:0] k_in;
  logic        data_xor;
  logic        par_bit;
  logic [10:0] frame;

  // Divisors below 2 are clamped so every bit lasts at least two cycles.
  assign k_in = (baud_k < 19'd2) ? 19'd2 : baud_k;

  // Frame is built from the latched copies only, so input changes during
  // a frame cannot disturb it.
  always_comb begin
    data_xor = eight_q ? (^data_q) : (^data_q[6:0]);
    par_bit  = pen_q ? (data_xor ^ ohel_q) : 1'b1;
    if (eight_q) frame = {1'b1, par_bit, data_q, 1'b0};
    else         frame = {2'b11, par_bit, data_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      txrdy    <= 1'b1;
      data_q   <= 8'd0;
      eight_q  <= 1'b0;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
      k_q      <= 19'd2;
      sr       <= '1;
      tick_cnt <= 19'd0;
      bit_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          txrdy <= 1'b1;
          if (load) begin
            data_q  <= out_port;
            eight_q <= eight;
            pen_q   <= pen;
            ohel_q  <= ohel;
            k_q     <= k_in;
            txrdy   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          sr       <= frame;
          tx       <= frame[0];
          tick_cnt <= 19'd0;
          bit_cnt  <= 4'd0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (tick_cnt == k_q - 19'd1) begin
            tick_cnt <= 19'd0;
            if (bit_cnt == 4'd10) begin
              // Last stop bit done: back to idle with tx and txrdy high
              // on the same edge.
              bit_cnt <= 4'd0;
              sr      <= '1;
              tx      <= 1'b1;
              txrdy   <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              sr      <= {1'b1, sr[10:1]};
              // sr[1] is the LSB after this shift, so tx tracks it.
              tx      <= sr[1];
            end
          end else begin
            tick_cnt <= tick_cnt + 19'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          txrdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine. Expected tx bit sequences are
// hand-computed constants, bit n of each vector is the n-th bit on the line.

module tb_uart_tx_engine;

  logic        clk;
  logic        reset;
  logic [18:0] baud_k;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic        load;
  logic [7:0]  out_port;
  logic        tx;
  logic        txrdy;

  int checks;
  int passes;
  int fails;

  uart_tx_engine dut (
    .clk      (clk),
    .reset    (reset),
    .baud_k   (baud_k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .load     (load),
    .out_port (out_port),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // there too, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Drives one frame. Caller sets config/out_port and load=1 before the
  // call; the first tick inside is the accepting edge E0.
  task automatic run_frame(input string tag, input logic [10:0] exp_bits,
                           input int k, input bit keep_load,
                           input logic [7:0] next_port, input bit disturb);
    tick();
    if (!keep_load) load = 1'b0;
    out_port = next_port;
    chk({tag, " txrdy@E0"}, txrdy, 1'b0);
    chk({tag, " tx@E0"}, tx, 1'b1);
    tick();
    for (int n = 0; n < 11; n++) begin
      for (int c = 0; c < k; c++) begin
        if (disturb && n == 3 && c == 0) begin
          load     = 1'b1;
          out_port = 8'hFF;
          baud_k   = 19'd7;
          eight    = 1'b0;
          pen      = 1'b0;
        end
        if (disturb && n == 3 && c == 1) load = 1'b0;
        chk($sformatf("%s bit%0d cyc%0d tx", tag, n, c), tx, exp_bits[n]);
        chk($sformatf("%s bit%0d cyc%0d txrdy", tag, n, c), txrdy, 1'b0);
        tick();
      end
    end
    chk({tag, " txrdy@end"}, txrdy, 1'b1);
    chk({tag, " tx@end"}, tx, 1'b1);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    fails    = 0;
    reset    = 1'b1;
    baud_k   = 19'd4;
    eight    = 1'b1;
    pen      = 1'b1;
    ohel     = 1'b0;
    load     = 1'b0;
    out_port = 8'h00;

    // Reset state
    tick(); tick(); tick();
    chk("reset tx", tx, 1'b1);
    chk("reset txrdy", txrdy, 1'b1);
    reset = 1'b0;
    tick();
    chk("post-reset tx", tx, 1'b1);
    chk("post-reset txrdy", txrdy, 1'b1);

    // Case 1: 8-bit even parity, 0xA5, K=4 -> 0,1,0,1,0,0,1,0,1,0,1
    baud_k = 19'd4; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    out_port = 8'hA5; load = 1'b1;
    run_frame("c1", 11'b10101001010, 4, 1'b0, 8'hA5, 1'b0);
    tick();

    // Case 2: 7-bit odd parity, 0x41, K=3 -> 0,1,0,0,0,0,0,1,1,1,1
    baud_k = 19'd3; eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    out_port = 8'h41; load = 1'b1;
    run_frame("c2", 11'b11110000010, 3, 1'b0, 8'h41, 1'b0);
    tick();

    // Case 3: no parity, baud_k=1 clamped to 2, 0x00 -> 0 x9, 1, 1
    baud_k = 19'd1; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    out_port = 8'h00; load = 1'b1;
    run_frame("c3", 11'b11000000000, 2, 1'b0, 8'h00, 1'b0);
    tick();

    // Case 4: 0x55 even parity K=2, load 0xFF and config change mid-frame
    // -> 0,1,0,1,0,1,0,1,0,0,1 and the 0xFF is dropped
    baud_k = 19'd2; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    out_port = 8'h55; load = 1'b1;
    run_frame("c4", 11'b10010101010, 2, 1'b0, 8'h55, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("c4 idle%0d tx", i), tx, 1'b1);
      chk($sformatf("c4 idle%0d txrdy", i), txrdy, 1'b1);
    end

    // Case 5: reset during bit 4 of a 0x00 frame, then a clean 0x3C frame
    baud_k = 19'd5; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    out_port = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    repeat (4 * 5 + 2) tick();
    chk("c5 bit4 tx", tx, 1'b0);
    chk("c5 bit4 txrdy", txrdy, 1'b0);
    reset = 1'b1;
    #1;
    chk("c5 async tx", tx, 1'b1);
    chk("c5 async txrdy", txrdy, 1'b1);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("c5 noresume%0d tx", i), tx, 1'b1);
      chk($sformatf("c5 noresume%0d txrdy", i), txrdy, 1'b1);
    end
    // 0x3C even parity -> 0,0,0,1,1,1,1,0,0,0,1
    out_port = 8'h3C; load = 1'b1;
    run_frame("c5", 11'b10001111000, 5, 1'b0, 8'h3C, 1'b0);
    tick();

    // Case 6: load held high, 0x81 then 0x7E, odd parity, K=3
    // 0x81 -> 0,1,0,0,0,0,0,0,1,1,1 ; 0x7E -> 0,0,1,1,1,1,1,1,0,1,1
    // The end-of-frame check (txrdy=1) plus the E0 check of the second
    // frame (txrdy=0) pin the idle gap to exactly one cycle.
    baud_k = 19'd3; eight = 1'b1; pen = 1'b1; ohel = 1'b1;
    out_port = 8'h81; load = 1'b1;
    run_frame("c6a", 11'b11100000010, 3, 1'b1, 8'h7E, 1'b0);
    run_frame("c6b", 11'b11011111100, 3, 1'b0, 8'h7E, 1'b0);
    tick();
    chk("c6 final tx", tx, 1'b1);
    chk("c6 final txrdy", txrdy, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
